// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants and the MODULUS-1 to BCD conversion
package bcd_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    localparam int MAX_DIGITS = 8;

    // Evaluated at elaboration only; the counter never converts binary at runtime.
    function automatic logic [DIGIT_W*MAX_DIGITS-1:0] to_bcd(input int value);
        logic [DIGIT_W*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD digit up/down step with ripple carry/borrow
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    input  logic               up,
    input  logic               step,
    output logic [DIGIT_W-1:0] q,
    output logic               ripple
);
    always_comb begin
        q      = d;
        ripple = 1'b0;
        if (step) begin
            if (up) begin
                if (d >= DIGIT_MAX) begin
                    q      = '0;
                    ripple = 1'b1;
                end else begin
                    q = d + 1'b1;
                end
            end else begin
                if (d == '0) begin
                    q      = DIGIT_MAX;
                    ripple = 1'b1;
                end else begin
                    q = d - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - multi-digit BCD up/down modulo counter with load, clear and wrap pulses
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] din,
    output logic [DIGIT_W*DIGITS-1:0] cnt,
    output logic                      co,
    output logic                      bo,
    output logic                      lderr
);
    localparam int W = DIGIT_W * DIGITS;
    localparam logic [DIGIT_W*MAX_DIGITS-1:0] LIMIT_FULL = to_bcd(MODULUS - 1);
    localparam logic [W-1:0] LIMIT = LIMIT_FULL[W-1:0];

    logic [DIGITS:0] chain;
    logic [W-1:0]    stepped;
    logic            din_ok;
    logic            wrap;

    assign chain[0] = 1'b1;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .d      (cnt[DIGIT_W*g +: DIGIT_W]),
                .up     (up),
                .step   (chain[g]),
                .q      (stepped[DIGIT_W*g +: DIGIT_W]),
                .ripple (chain[g+1])
            );
        end
    endgenerate

    // With every digit valid, an unsigned compare of BCD words matches numeric order.
    always_comb begin
        din_ok = (din <= LIMIT);
        for (int i = 0; i < DIGITS; i++) begin
            if (din[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX) din_ok = 1'b0;
        end
    end

    // Ripple out of the top digit only happens at all-9s or all-0s, which are wrap points too.
    assign wrap = (up ? (cnt == LIMIT) : (cnt == '0)) | chain[DIGITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            co    <= 1'b0;
            bo    <= 1'b0;
            lderr <= 1'b0;
        end else begin
            co    <= 1'b0;
            bo    <= 1'b0;
            lderr <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (load) begin
                if (din_ok) cnt <= din;
                else        lderr <= 1'b1;
            end else if (en) begin
                if (wrap) begin
                    cnt <= up ? '0 : LIMIT;
                    co  <= up;
                    bo  <= ~up;
                end else begin
                    cnt <= stepped;
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - directed self-checking bench for bcd_mod_counter
module tb_bcd_mod_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] cnt;
    logic       co, bo, lderr;
    logic       en_b = 1'b0, up_b = 1'b0, clr_b = 1'b0, load_b = 1'b0;
    logic [7:0] din_b = '0;
    logic [7:0] cnt_b;
    logic       co_b, bo_b, lderr_b;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .din(din),
        .cnt(cnt), .co(co), .bo(bo), .lderr(lderr)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) dut60 (
        .clk(clk), .rst(rst), .en(en_b), .up(up_b), .clr(clr_b), .load(load_b), .din(din_b),
        .cnt(cnt_b), .co(co_b), .bo(bo_b), .lderr(lderr_b)
    );

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] c, input logic e_co,
                         input logic e_bo, input logic e_lderr);
        chk({tag, ".cnt"}, cnt, c);
        chk({tag, ".co"}, co, e_co);
        chk({tag, ".bo"}, bo, e_bo);
        chk({tag, ".lderr"}, lderr, e_lderr);
    endtask

    initial begin
        tick();
        tick();
        chk_a("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset60.cnt", cnt_b, 8'h00);
        rst = 1'b1;

        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            chk($sformatf("up%0d.cnt", i), cnt, bcd2(i % 24));
            chk($sformatf("up%0d.co", i), co, (i == 24) ? 1'b1 : 1'b0);
        end
        en = 1'b0;
        tick();
        chk_a("co_one_cycle", 8'h00, 1'b0, 1'b0, 1'b0);

        en = 1'b1; up = 1'b0;
        tick();
        chk_a("down_wrap", 8'h23, 1'b0, 1'b1, 1'b0);
        tick();
        chk_a("down_after", 8'h22, 1'b0, 1'b0, 1'b0);
        en = 1'b0;

        load = 1'b1; din = 8'h20;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        chk_a("borrow_20_19", 8'h19, 1'b0, 1'b0, 1'b0);
        en = 1'b0;

        load = 1'b1; din = 8'h19;
        tick();
        chk_a("load19", 8'h19, 1'b0, 1'b0, 1'b0);
        din = 8'h25;
        tick();
        chk_a("load25", 8'h19, 1'b0, 1'b0, 1'b1);
        din = 8'h1A;
        tick();
        chk_a("load1A", 8'h19, 1'b0, 1'b0, 1'b1);
        load = 1'b0;
        tick();
        chk_a("hold", 8'h19, 1'b0, 1'b0, 1'b0);

        load = 1'b1; din = 8'h15;
        tick();
        chk("load15.cnt", cnt, 8'h15);
        clr = 1'b1; din = 8'h19; en = 1'b1; up = 1'b1;
        tick();
        chk_a("clr_prio", 8'h00, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; load = 1'b0; en = 1'b0;

        load_b = 1'b1; din_b = 8'h59;
        tick();
        chk("m60_load59", cnt_b, 8'h59);
        load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        tick();
        chk("m60_upwrap.cnt", cnt_b, 8'h00);
        chk("m60_upwrap.co", co_b, 1'b1);
        up_b = 1'b0;
        tick();
        chk("m60_downwrap.cnt", cnt_b, 8'h59);
        chk("m60_downwrap.bo", bo_b, 1'b1);
        chk("m60_downwrap.co", co_b, 1'b0);
        en_b = 1'b0; load_b = 1'b1; din_b = 8'h60;
        tick();
        chk("m60_load60.lderr", lderr_b, 1'b1);
        chk("m60_load60.cnt", cnt_b, 8'h59);
        load_b = 1'b0;

        load = 1'b1; din = 8'h17;
        tick();
        din = 8'h99;
        tick();
        chk_a("pre_async", 8'h17, 1'b0, 1'b0, 1'b1);
        load = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk_a("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        en = 1'b1; up = 1'b1;
        tick();
        chk_a("after_rst", 8'h01, 1'b0, 1'b0, 1'b0);
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
